// File: rtl/flash_pkg.sv
// Shared types and constants for the flash read responder.
package flash_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STALL,
      ST_ACCEPT
   } state_e;

   localparam logic [31:0] DATA_TAG         = 32'hF1A5_0000;
   localparam int          DEF_ADDR_W       = 16;
   localparam int          DEF_WAIT_CYCLES  = 2;
   localparam int          DEF_READ_LATENCY = 3;

   function automatic logic [31:0] make_word(input logic [15:0] addr);
      return DATA_TAG | {16'h0000, addr};
   endfunction

endpackage

// File: rtl/flash_responder_latency_pipe.sv
// Fixed-depth shift register carrying {valid, address} from accept to data return.
module latency_pipe #(
   parameter int DEPTH  = 3,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_vld,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              out_vld,
   output logic [ADDR_W-1:0] out_addr
);

   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];

   always_comb begin
      vld_d[0]  = in_vld;
      addr_d[0] = in_addr;
      for (int i = 1; i < DEPTH; i++) begin
         vld_d[i]  = vld_q[i-1];
         addr_d[i] = addr_q[i-1];
      end
   end

   // Reset empties the pipe so reads in flight are dropped, not returned later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
      end else begin
         vld_q  <= vld_d;
         addr_q <= addr_d;
      end
   end

   assign out_vld  = vld_q[DEPTH-1];
   assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/flash_responder.sv
// Avalon-style read responder: fixed stall before each accept, fixed read latency.
module flash_responder
   import flash_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int WAIT_CYCLES  = DEF_WAIT_CYCLES,
   parameter int READ_LATENCY = DEF_READ_LATENCY
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              read,
   input  logic [ADDR_W-1:0] address,
   output logic              waitrequest,
   output logic [31:0]       readdata,
   output logic              readdatavalid,
   output logic              protocol_err,
   output logic [15:0]       reads_served
);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
   logic              err_q, err_d;
   logic [15:0]       served_q, served_d;
   logic              accept;
   logic              pipe_vld;
   logic [ADDR_W-1:0] pipe_addr;
   logic [15:0]       pipe_addr_ext;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lat_addr_d = lat_addr_q;
      err_d      = err_q;
      accept     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (read) begin
               lat_addr_d = address;
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_ACCEPT;
               end else begin
                  state_d = ST_STALL;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end
         ST_STALL: begin
            if (!read) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else if (cnt_q <= 4'd1) begin
               state_d = ST_ACCEPT;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACCEPT: begin
            state_d = ST_IDLE;
            if (!read) err_d  = 1'b1;
            else       accept = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      // Master must hold the address steady once a request has been seen.
      if ((state_q == ST_STALL || state_q == ST_ACCEPT) && read && address != lat_addr_q)
         err_d = 1'b1;
      served_d = served_q + {15'd0, pipe_vld};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         lat_addr_q <= '0;
         err_q      <= 1'b0;
         served_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lat_addr_q <= lat_addr_d;
         err_q      <= err_d;
         served_q   <= served_d;
      end
   end

   latency_pipe #(
      .DEPTH  (READ_LATENCY),
      .ADDR_W (ADDR_W)
   ) u_pipe (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_vld   (accept),
      .in_addr  (address),
      .out_vld  (pipe_vld),
      .out_addr (pipe_addr)
   );

   always_comb begin
      pipe_addr_ext             = '0;
      pipe_addr_ext[ADDR_W-1:0] = pipe_addr;
   end

   assign waitrequest   = (state_q != ST_ACCEPT);
   assign readdatavalid = pipe_vld;
   assign readdata      = pipe_vld ? make_word(pipe_addr_ext) : 32'h0;
   assign protocol_err  = err_q;
   assign reads_served  = served_q;

endmodule
